// File: rtl/switch_pkg.sv
// Shared types and register-map helpers for the multi-channel ingress queue.
package switch_pkg;

  typedef enum logic {
    ARB_STRICT = 1'b0,
    ARB_RR     = 1'b1
  } arb_mode_t;

  localparam int unsigned REG_CTRL       = 0;
  localparam int unsigned CTRL_MODE_BIT  = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;

  function automatic int unsigned reg_full(input int unsigned num_ch);
    return num_ch + 1;
  endfunction

  function automatic int unsigned reg_ovf(input int unsigned num_ch);
    return num_ch + 2;
  endfunction

endpackage

// File: rtl/switch_ingress_queue_if.sv
// Avalon-MM slave bus plus the arbitrated valid/ready output stream.
interface switch_ingress_queue_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) ();

  localparam int unsigned ChW = $clog2(NUM_CH);

  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ChW-1:0]    out_ch;

  modport master (
    output chipselect, write, read, address, writedata, out_ready,
    input  readdata, out_valid, out_data, out_ch
  );

  modport slave (
    input  chipselect, write, read, address, writedata, out_ready,
    output readdata, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/ingress_fifo.sv
// Single-channel show-ahead FIFO with synchronous flush; push to full and pop of empty are ignored.
module ingress_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CntW-1:0]   count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/switch_ingress_queue.sv
// Multi-channel ingress queue: bus-fed per-channel FIFOs drained by a strict/RR arbiter.
module switch_ingress_queue
  import switch_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  switch_ingress_queue_if.slave  bus
);

  localparam int unsigned ChW     = $clog2(NUM_CH);
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned RegFull = reg_full(NUM_CH);
  localparam int unsigned RegOvf  = reg_ovf(NUM_CH);

  logic [DATA_W-1:0] fifo_dout  [NUM_CH];
  logic [CntW-1:0]   fifo_count [NUM_CH];
  logic [NUM_CH-1:0] push_vec, pop_vec, empty_vec, full_vec, ovf_event;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  arb_mode_t         mode_q, mode_d;
  logic [ChW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ChW-1:0]    grant;
  logic [DATA_W-1:0] grant_data;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ChW-1:0]    out_ch_q, out_ch_d;
  logic [DATA_W-1:0] readdata_q, readdata_d, rd_val;
  logic [NUM_CH:0]   ctrl_vec;
  logic              wr_en, rd_en, flush, load;
  int                addr_i;

  always_comb begin
    addr_i = int'(bus.address);
    wr_en  = bus.chipselect && bus.write;
    rd_en  = bus.chipselect && bus.read;
    flush  = wr_en && (addr_i == int'(REG_CTRL)) && bus.writedata[CTRL_FLUSH_BIT];
    for (int k = 0; k < int'(NUM_CH); k++) begin
      push_vec[k]  = wr_en && (addr_i == k + 1) && !flush;
      ovf_event[k] = push_vec[k] && full_vec[k];
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_fifo
    ingress_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (push_vec[g]),
      .pop    (pop_vec[g]),
      .flush  (flush),
      .din    (bus.writedata),
      .dout   (fifo_dout[g]),
      .count  (fifo_count[g]),
      .empty  (empty_vec[g]),
      .full   (full_vec[g])
    );
  end

  // Grant selection; RR scans from the channel after the last grant and wraps.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (mode_q == ARB_STRICT) begin
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
        if (!empty_vec[k]) grant = ChW'(k);
      end
    end else begin
      for (int off = 1; off <= int'(NUM_CH); off++) begin
        idx = (int'(rr_ptr_q) + off) % int'(NUM_CH);
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (!found && (k == idx) && !empty_vec[k]) begin
            grant = ChW'(k);
            found = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    load       = (!out_valid_q || bus.out_ready) && (|(~empty_vec)) && !flush;
    grant_data = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      pop_vec[k] = load && (grant == ChW'(k));
      if (grant == ChW'(k)) grant_data = fifo_dout[k];
    end
  end

  always_comb begin
    ctrl_vec = {mode_q == ARB_RR, empty_vec};
    rd_val   = '0;
    if (addr_i == int'(REG_CTRL)) rd_val = DATA_W'(ctrl_vec);
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (addr_i == k + 1) rd_val = DATA_W'(fifo_count[k]);
    end
    if (addr_i == int'(RegFull)) rd_val = DATA_W'(full_vec);
    if (addr_i == int'(RegOvf))  rd_val = DATA_W'(ovf_q);
  end

  always_comb begin
    mode_d      = mode_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    readdata_d  = readdata_q;
    ovf_d       = ovf_q | ovf_event;

    if (wr_en && (addr_i == int'(REG_CTRL))) begin
      mode_d = arb_mode_t'(bus.writedata[CTRL_MODE_BIT]);
    end
    if (flush) begin
      out_valid_d = 1'b0;
      ovf_d       = '0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant;
      rr_ptr_d    = grant;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // Clear-on-read still keeps an overflow that lands in the read cycle.
    if (!flush && rd_en && (addr_i == int'(RegOvf))) ovf_d = ovf_event;
    if (rd_en) readdata_d = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= ARB_STRICT;
      rr_ptr_q    <= ChW'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      readdata_q  <= '0;
      ovf_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      readdata_q  <= readdata_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.readdata  = readdata_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_switch_ingress_queue.sv
// Directed and randomized bench for switch_ingress_queue against a queue-based reference model.
module tb_switch_ingress_queue;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int AW  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  switch_ingress_queue_if #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW)) bus ();

  switch_ingress_queue #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] mq [NCH][$];
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  bit         m_mode;
  int         m_ptr;
  logic [3:0] m_ovf;
  logic [7:0] m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_valid = 0; m_data = 0; m_ch = 0; m_mode = 0; m_ptr = NCH - 1; m_ovf = 0; m_rd = 0;
  endtask

  task automatic model_step(input bit w, input bit r, input int a, input logic [7:0] d,
                            input bit rdy);
    bit         flush;
    bit         acc;
    int         g;
    logic [7:0] rv;
    logic [3:0] ev;
    logic [3:0] emp;
    logic [3:0] ful;
    flush = w && (a == 0) && d[1];
    for (int i = 0; i < NCH; i++) begin
      emp[i] = (mq[i].size() == 0);
      ful[i] = (mq[i].size() == DEP);
    end
    rv = 0;
    if (a == 0) rv = {3'b000, m_mode, emp};
    else if (a >= 1 && a <= NCH) rv = 8'(mq[a-1].size());
    else if (a == NCH + 1) rv = {4'b0000, ful};
    else if (a == NCH + 2) rv = {4'b0000, m_ovf};
    ev = 0;
    acc = 0;
    if (w && a >= 1 && a <= NCH) begin
      if (mq[a-1].size() == DEP) ev[a-1] = 1'b1;
      else acc = 1;
    end
    g = -1;
    if ((!m_valid || rdy) && !flush) begin
      if (!m_mode) begin
        for (int i = 0; i < NCH; i++) if (g < 0 && mq[i].size() > 0) g = i;
      end else begin
        for (int off = 1; off <= NCH; off++) begin
          int j;
          j = (m_ptr + off) % NCH;
          if (g < 0 && mq[j].size() > 0) g = j;
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_valid = 0;
      m_ovf = 0;
    end else begin
      if (g >= 0) begin
        m_data = mq[g].pop_front();
        m_ch = g; m_ptr = g; m_valid = 1;
      end else if (rdy) begin
        m_valid = 0;
      end
      if (acc) mq[a-1].push_back(d);
      if (r && a == NCH + 2) m_ovf = ev;
      else m_ovf = m_ovf | ev;
    end
    if (w && a == 0) m_mode = d[0];
    if (r) m_rd = rv;
  endtask

  // One bus cycle: drive, advance the model, clock, then compare.
  task automatic cyc(input bit w, input bit r, input int a, input logic [7:0] d, input bit rdy);
    bus.chipselect = w | r;
    bus.write = w;
    bus.read = r;
    bus.address = AW'(a);
    bus.writedata = d;
    bus.out_ready = rdy;
    model_step(w, r, a, d, rdy);
    @(posedge clk);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_data", 32'(bus.out_data), 32'(m_data));
      check("out_ch", 32'(bus.out_ch), 32'(m_ch));
    end
    if (r) check("readdata", 32'(bus.readdata), 32'(m_rd));
    bus.chipselect = 0;
    bus.write = 0;
    bus.read = 0;
  endtask

  initial begin
    bus.chipselect = 0; bus.write = 0; bus.read = 0;
    bus.address = '0; bus.writedata = '0; bus.out_ready = 0;
    model_reset();
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_readdata", 32'(bus.readdata), 32'd0);
    #9 reset_n = 1'b1;

    // Reset register view
    cyc(0, 1, 0, 0, 1);
    check("ctrl_after_reset", 32'(bus.readdata), 32'h0F);
    cyc(0, 1, NCH + 1, 0, 1);
    check("full_after_reset", 32'(bus.readdata), 32'h00);

    // Single word latency
    cyc(1, 0, 2, 8'hA1, 1);
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    cyc(0, 0, 0, 0, 1);
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_data", 32'(bus.out_data), 32'hA1);
    cyc(0, 1, 2, 0, 1);

    // Overflow and clear-on-read
    for (int i = 0; i <= 8; i++) cyc(1, 0, 1, 8'(i), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 8'h09, 0);
    cyc(1, 0, 1, 8'h0A, 0);
    cyc(0, 1, NCH + 1, 0, 0);
    cyc(0, 1, NCH + 2, 0, 0);
    check("ovf_first_read", 32'(bus.readdata), 32'h01);
    cyc(0, 1, NCH + 2, 0, 0);
    check("ovf_second_read", 32'(bus.readdata), 32'h00);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 1);

    // Strict then round-robin
    for (int m = 0; m < 2; m++) begin
      cyc(1, 0, 0, 8'(m), 0);
      for (int c = 0; c < NCH; c++) begin
        cyc(1, 0, c + 1, 8'(16 * c + 1), 0);
        cyc(1, 0, c + 1, 8'(16 * c + 2), 0);
      end
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    end

    // Flush
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2, 8'(8'h20 + i), 0);
      cyc(1, 0, 4, 8'(8'h40 + i), 0);
    end
    cyc(1, 0, 0, 8'h02, 0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    for (int c = 0; c <= NCH; c++) cyc(0, 1, c, 0, 0);
    check("flush_ctrl", 32'(bus.readdata), 32'h00);
    cyc(0, 1, 0, 0, 0);
    check("flush_empty", 32'(bus.readdata), 32'h0F);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8'(8'h50 + i), 0);
    cyc(0, 1, 1, 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 32'd0);
    check("async_readdata", 32'(bus.readdata), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 0, 3, 8'h77, 1);
    cyc(0, 0, 0, 0, 1);
    check("post_reset_data", 32'(bus.out_data), 32'h77);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int op;
      bit rdy;
      op  = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      if (op < 55) cyc(1, 0, int'($urandom_range(1, NCH)), 8'($urandom), rdy);
      else if (op < 58) cyc(1, 0, 0, 8'($urandom_range(0, 1)), rdy);
      else if (op < 59) cyc(1, 0, 0, 8'(2 + $urandom_range(0, 1)), rdy);
      else if (op < 85) cyc(0, 1, int'($urandom_range(0, 7)), 0, rdy);
      else cyc(0, 0, 0, 0, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
